serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_fa_slice.sv | 35 +++
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// serial_add_ctrl also honours the SERIAL_ADD_SUB_EN macro (adds a subtract mode).
package serial_add_pkg;

  localparam int unsigned DefWidth = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_fa_slice.sv
// One full-adder slice with its carry flop; the carry is preloaded on load and
// advanced on en. Maps to a single full-adder cell plus one D flop.
module serial_fa_slice (
  input  logic CP,
  input  logic RN,
  input  logic load,
  input  logic en,
  input  logic load_cin,
  input  logic a_bit,
  input  logic b_bit,
  output logic s_bit,
  output logic carry
);

  logic r_carry;
  logic w_carry_next;

  always_comb begin
    s_bit        = a_bit ^ b_bit ^ r_carry;
    w_carry_next = (a_bit & b_bit) | (a_bit & r_carry) | (b_bit & r_carry);
  end

  always_ff @(posedge CP) begin
    if (!RN) begin
      r_carry <= 1'b0;
    end else if (load) begin
      r_carry <= load_cin;
    end else if (en) begin
      r_carry <= w_carry_next;
    end
  end

  assign carry = r_carry;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial a+b+cin, one bit per CP cycle, LSB first, with registered busy/done.
// Defining SERIAL_ADD_SUB_EN adds input sub: sub=1 computes a-b (cout=1 means no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             CP,
  input  logic             RN,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;

  logic             w_load;
  logic             w_shift;
  logic             w_s_bit;
  logic             w_carry;
  logic             w_load_cin;
  logic [WIDTH-1:0] w_b_load;
  logic [WIDTH-1:0] w_sum_next;

  always_comb begin
    w_load  = (r_state == IDLE) && start;
    w_shift = (r_state == SHIFT);
`ifdef SERIAL_ADD_SUB_EN
    // Two's complement subtract: invert b and force the carry-in high.
    w_b_load   = sub ? ~b : b;
    w_load_cin = sub | cin;
`else
    w_b_load   = b;
    w_load_cin = cin;
`endif
    w_sum_next             = r_sum >> 1;
    w_sum_next[WIDTH-1]    = w_s_bit;
  end

  serial_fa_slice u_slice (
    .CP      (CP),
    .RN      (RN),
    .load    (w_load),
    .en      (w_shift),
    .load_cin(w_load_cin),
    .a_bit   (r_a[0]),
    .b_bit   (r_b[0]),
    .s_bit   (w_s_bit),
    .carry   (w_carry)
  );

  always_ff @(posedge CP) begin
    if (!RN) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_busy <= 1'b1;
          r_done <= 1'b0;
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_sum  <= w_sum_next;
          r_cnt  <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // Carry flop holds the final carry once shifting stops.
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_cout  <= w_carry;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
